bram_march_tester: RTL and testbench

//  Upstream driver for the 256x16 block-RAM instance. Writes a deterministic

---
 rtl/bram_march_tester.sv | 175 +++++++++++++++++
 tb/tb_bram_march_tester.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_march_tester.sv
// Purpose: march-style self test for a 2**ADDR_W x DATA_W block RAM (write pattern, read back, compare; optional complemented pass).
// Latency: per phase 2*2**ADDR_W + RD_LAT cycles after the accept edge; done is a single-cycle pulse.
// Backpressure: none; start is sampled only in IDLE and ignored while busy or in DONE (no queuing).
module bram_march_tester #(
  parameter int               ADDR_W      = 8,
  parameter int               DATA_W      = 16,     // must equal 2*ADDR_W
  parameter logic [DATA_W-1:0] SEED       = 16'hA5C3,
  parameter int               RD_LAT      = 1,      // 1..4
  parameter bit               INVERT_PASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_wclke,
  output logic [DATA_W-1:0] ram_mask,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_re,
  output logic              ram_rclke,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(RD_LAT - 1);

  state_t              state;
  logic                phase;
  logic [ADDR_W-1:0]   cnt;

  logic [RD_LAT-1:0]   pipe_vld;
  logic [ADDR_W-1:0]   pipe_addr [RD_LAT];

  logic                mismatch;
  logic [7:0]          err_next;
  logic [ADDR_W-1:0]   fea_next;

  // Address-derived test word; phase 1 is the bitwise complement of phase 0.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic ph);
    return {a, ~a} ^ SEED ^ {DATA_W{ph}};
  endfunction

  // Every bit is always written.
  assign ram_mask = '0;

  // Track issued read addresses so each returning word is compared against its own address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_addr[i] <= '0;
    end else begin
      pipe_vld[0]  <= ram_re;
      pipe_addr[0] <= ram_raddr;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  // Compare returning data and form the next error count / first failing address.
  always_comb begin
    err_next = err_count;
    fea_next = first_err_addr;
    mismatch = pipe_vld[RD_LAT-1] &&
               (ram_rdata != pattern(pipe_addr[RD_LAT-1], phase));
    if (mismatch) begin
      if (err_count != 8'hFF) err_next = err_count + 8'd1;
      if (err_count == 8'h00) fea_next = pipe_addr[RD_LAT-1];
    end
  end

  // Test sequencer; all status and RAM controls are registered here, set for the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      phase          <= 1'b0;
      cnt            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      ram_waddr      <= '0;
      ram_wdata      <= '0;
      ram_we         <= 1'b0;
      ram_wclke      <= 1'b0;
      ram_raddr      <= '0;
      ram_re         <= 1'b0;
      ram_rclke      <= 1'b0;
    end else begin
      done           <= 1'b0;
      err_count      <= err_next;
      first_err_addr <= fea_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_WRITE;
            phase          <= 1'b0;
            cnt            <= '0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            ram_we         <= 1'b1;
            ram_wclke      <= 1'b1;
            ram_waddr      <= '0;
            ram_wdata      <= pattern('0, 1'b0);
          end
        end
        S_WRITE: begin
          if (cnt == '1) begin
            state     <= S_READ;
            cnt       <= '0;
            ram_we    <= 1'b0;
            ram_wclke <= 1'b0;
            ram_re    <= 1'b1;
            ram_rclke <= 1'b1;
            ram_raddr <= '0;
          end else begin
            cnt       <= cnt + 1'b1;
            ram_waddr <= cnt + 1'b1;
            ram_wdata <= pattern(cnt + 1'b1, phase);
          end
        end
        S_READ: begin
          if (cnt == '1) begin
            state     <= S_DRAIN;
            cnt       <= '0;
            ram_re    <= 1'b0;
            ram_rclke <= 1'b0;
          end else begin
            cnt       <= cnt + 1'b1;
            ram_raddr <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          // The last read's comparison lands on the final drain cycle, so pass uses err_next.
          if (cnt == DRAIN_LAST) begin
            cnt <= '0;
            if (INVERT_PASS && !phase) begin
              state     <= S_WRITE;
              phase     <= 1'b1;
              ram_we    <= 1'b1;
              ram_wclke <= 1'b1;
              ram_waddr <= '0;
              ram_wdata <= pattern('0, 1'b1);
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= (err_next == 8'h00);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_march_tester.sv
// Bench for bram_march_tester: two instances (default, and RD_LAT=2 single phase)
// each driving a behavioural RAM with optional read faults; run results are
// scoreboarded at start time and checked when done pulses.
module tb_bram_march_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic rst_n;

  // Instance 1: defaults (RD_LAT=1, two phases)
  logic        start1, busy1, done1, pass1, we1, wclke1, re1, rclke1;
  logic [7:0]  errc1, fea1, waddr1, raddr1;
  logic [15:0] wdata1, mask1, rdata1;

  // Instance 2: RD_LAT=2, single phase
  logic        start2, busy2, done2, pass2, we2, wclke2, re2, rclke2;
  logic [7:0]  errc2, fea2, waddr2, raddr2;
  logic [15:0] wdata2, mask2, rdata2;

  bram_march_tester u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(errc1), .first_err_addr(fea1),
    .ram_waddr(waddr1), .ram_wdata(wdata1), .ram_we(we1), .ram_wclke(wclke1),
    .ram_mask(mask1), .ram_raddr(raddr1), .ram_re(re1), .ram_rclke(rclke1),
    .ram_rdata(rdata1)
  );

  bram_march_tester #(.RD_LAT(2), .INVERT_PASS(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(errc2), .first_err_addr(fea2),
    .ram_waddr(waddr2), .ram_wdata(wdata2), .ram_we(we2), .ram_wclke(wclke2),
    .ram_mask(mask2), .ram_raddr(raddr2), .ram_re(re2), .ram_rclke(rclke2),
    .ram_rdata(rdata2)
  );

  // RAM fault modes: 0 ideal, 1 bits in fmask read as 0 at faddr, 2 every read all-ones
  int          mode1 = 0, mode2 = 0;
  logic [7:0]  faddr1 = '0, faddr2 = '0;
  logic [15:0] fmask1 = '0, fmask2 = '0;

  function automatic logic [15:0] corrupt(input logic [15:0] d, input logic [7:0] a,
                                          input int mode, input logic [7:0] fa,
                                          input logic [15:0] fm);
    if (mode == 2) return 16'hFFFF;
    if (mode == 1 && a == fa) return d & ~fm;
    return d;
  endfunction

  logic [15:0] mem1 [256];
  logic [15:0] mem2 [256];
  logic [15:0] rd1_q, rd2_q0, rd2_q1;

  always @(posedge clk) begin
    if (we1) mem1[waddr1] <= (wdata1 & ~mask1) | (mem1[waddr1] & mask1);
    if (re1) rd1_q <= corrupt(mem1[raddr1], raddr1, mode1, faddr1, fmask1);
    if (we2) mem2[waddr2] <= (wdata2 & ~mask2) | (mem2[waddr2] & mask2);
    if (re2) rd2_q0 <= corrupt(mem2[raddr2], raddr2, mode2, faddr2, fmask2);
    rd2_q1 <= rd2_q0;
  end
  assign rdata1 = rd1_q;
  assign rdata2 = rd2_q1;

  typedef struct {
    int         done_cyc;
    logic       pass;
    logic [7:0] errc;
    logic [7:0] fea;
  } res_t;

  res_t sb1[$];
  res_t sb2[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Control ties and write/read exclusivity, every cycle out of reset
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("ties1", {wclke1, rclke1, we1 & re1, |mask1}, {we1, re1, 1'b0, 1'b0});
      chk("ties2", {wclke2, rclke2, we2 & re2, |mask2}, {we2, re2, 1'b0, 1'b0});
    end
  end

  // Raise start for one cycle (sampled at the end of the next negedge-aligned cycle)
  task automatic kick(input int which, input int len, input logic p, input logic [7:0] e,
                      input logic [7:0] f, input bit push);
    res_t r;
    @(negedge clk);
    r.done_cyc = cyc + len;
    r.pass     = p;
    r.errc     = e;
    r.fea      = f;
    if (which == 1) begin
      start1 = 1'b1;
      if (push) sb1.push_back(r);
    end else begin
      start2 = 1'b1;
      if (push) sb2.push_back(r);
    end
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input int which, input string tag);
    bit   got;
    int   sz;
    res_t r;
    logic d;
    got = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      d = (which == 1) ? done1 : done2;
      if (d) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, got, 1);
    if (got) begin
      sz = (which == 1) ? sb1.size() : sb2.size();
      chk({tag, "_sb_entry"}, sz > 0, 1);
      if (sz > 0) begin
        r = (which == 1) ? sb1.pop_front() : sb2.pop_front();
        chk({tag, "_done_cyc"}, cyc, r.done_cyc);
        chk({tag, "_pass"},  (which == 1) ? pass1 : pass2, r.pass);
        chk({tag, "_errc"},  (which == 1) ? errc1 : errc2, r.errc);
        chk({tag, "_fea"},   (which == 1) ? fea1  : fea2,  r.fea);
        chk({tag, "_busy"},  (which == 1) ? busy1 : busy2, 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    rst_n  = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_status1", {busy1, done1, pass1, errc1, fea1}, 0);
    chk("rst_ram1", {we1, wclke1, re1, rclke1, waddr1, raddr1, wdata1, mask1}, 0);
    chk("rst_status2", {busy2, done2, pass2, errc2, fea2}, 0);
    chk("rst_ram2", {we2, re2, waddr2, raddr2, wdata2}, 0);
    rst_n = 1'b1;

    // 1: ideal RAM, start during cycle 10, done in cycle 1037
    while (cyc < 9) @(negedge clk);
    kick(1, 1027, 1'b1, 8'h00, 8'h00, 1'b1);
    chk("t1_first_write", {busy1, we1, waddr1, wdata1}, {1'b1, 1'b1, 8'h00, 16'hA53C});
    while (cyc < 267) @(negedge clk);
    chk("t1_first_read", {we1, re1, raddr1}, {1'b0, 1'b1, 8'h00});
    while (cyc < 523) @(negedge clk);
    chk("t1_drain", {busy1, we1, re1}, {1'b1, 1'b0, 1'b0});
    @(negedge clk);
    chk("t1_ph1_write", {we1, waddr1, wdata1}, {1'b1, 8'h00, 16'h5AC3});
    wait_done(1, "t1");

    // 2: bit 3 of address 0x10 reads as 0 (only phase 0 expects a 1 there)
    mode1 = 1; faddr1 = 8'h10; fmask1 = 16'h0008;
    kick(1, 1027, 1'b0, 8'd1, 8'h10, 1'b1);
    wait_done(1, "t2");

    // 3: all-ones RAM, error count saturates
    mode1 = 2;
    kick(1, 1027, 1'b0, 8'hFF, 8'h00, 1'b1);
    wait_done(1, "t3");
    // start during DONE must be ignored, status held
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    chk("t3_start_in_done", {busy1, we1, done1}, 0);
    chk("t3_status_held", {pass1, errc1}, {1'b0, 8'hFF});

    // 4: reset at write address 100, then a clean rerun
    mode1 = 0;
    kick(1, 0, 1'b1, 8'h00, 8'h00, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (we1 && waddr1 == 8'd100) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("t4_reached_100", hit, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_abort", {we1, busy1, done1, re1, waddr1, wdata1}, 0);
    rst_n = 1'b1;
    kick(1, 1027, 1'b1, 8'h00, 8'h00, 1'b1);
    chk("t4_rewrite", {we1, waddr1, wdata1}, {1'b1, 8'h00, 16'hA53C});
    wait_done(1, "t4");

    // 5: start held high across two runs
    @(negedge clk);
    start1 = 1'b1;
    sb1.push_back('{cyc + 1027, 1'b1, 8'h00, 8'h00});
    wait_done(1, "t5a");
    @(negedge clk);
    chk("t5_idle_gap", {busy1, we1}, 0);
    sb1.push_back('{cyc + 1027, 1'b1, 8'h00, 8'h00});
    @(negedge clk);
    chk("t5_rerun", {busy1, we1, waddr1, wdata1}, {1'b1, 1'b1, 8'h00, 16'hA53C});
    start1 = 1'b0;
    wait_done(1, "t5b");

    // 6: RD_LAT=2, single phase; then faults on the last two addresses
    kick(2, 515, 1'b1, 8'h00, 8'h00, 1'b1);
    wait_done(2, "t6");
    mode2 = 1; faddr2 = 8'hFF; fmask2 = 16'h0001;
    kick(2, 515, 1'b0, 8'd1, 8'hFF, 1'b1);
    wait_done(2, "t6_ff");
    faddr2 = 8'hFE; fmask2 = 16'h0002;
    kick(2, 515, 1'b0, 8'd1, 8'hFE, 1'b1);
    wait_done(2, "t6_fe");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
